// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: address width and pointer-to-occupancy math.
package fifo_pkg;

   function automatic int addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Pointers carry a wrap bit, so the masked difference is the true occupancy.
   function automatic logic [31:0] ptr_to_count(input logic [31:0] wr_ptr,
                                                input logic [31:0] rd_ptr,
                                                input int          ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << ptr_w) - 32'd1;
      return (wr_ptr - rd_ptr) & mask;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy flags, sticky error flags and a selectable
// registered or first-word-fall-through read port.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [ADDR_W:0]       wr_ptr;
   logic [ADDR_W:0]       rd_ptr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  wr_acc;
   logic                  rd_acc;

   assign count        = ($clog2(DEPTH)+1)'(ptr_to_count(32'(wr_ptr), 32'(rd_ptr), PTR_W));
   assign full         = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= ($clog2(DEPTH)+1)'(AF_LEVEL));
   assign almost_empty = (count <= ($clog2(DEPTH)+1)'(AE_LEVEL));

   // Acceptance uses pre-edge flags, so a simultaneous read never frees room for a write.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && full)  overflow  <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (mem_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = mem_rdata;
         assign rd_valid = !empty;
      end else begin : g_std
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) rd_data <= mem_rdata;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard-mode FIFO plus a FWFT instance sharing the clock.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wr_en, rd_en;
   logic [7:0] wr_data, rd_data;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   logic       wr_en1, rd_en1;
   logic [7:0] wr_data1, rd_data1;
   logic       rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [3:0] count1;

   int n_checks = 0;
   int n_fail   = 0;

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(udf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      wr_en1 = 1'b0; rd_en1 = 1'b0; wr_data1 = 8'h00;
      tick(); tick();
      rst = 1'b0;
      n_checks++;
      if ({count, empty, almost_empty, full, almost_full, overflow, underflow, rd_valid} !==
          {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL reset_flags: count=%0d e=%b ae=%b f=%b af=%b ovf=%b udf=%b v=%b, want 0 1 1 0 0 0 0 0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow, rd_valid);
         n_fail++;
      end
      n_checks++;
      if (rd_data !== 8'h00) begin
         $display("FAIL reset_rd_data: got %h want 00", rd_data);
         n_fail++;
      end
      n_checks++;
      if ({count1, empty1, rd_valid1} !== {4'd0, 1'b1, 1'b0}) begin
         $display("FAIL reset_fwft: count=%0d e=%b v=%b want 0 1 0", count1, empty1, rd_valid1);
         n_fail++;
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         tick();
         n_checks++;
         if ({count, almost_full, full, empty, almost_empty} !==
             {4'(i + 1), (i + 1 >= 6), (i + 1 == 8), 1'b0, (i + 1 <= 2)}) begin
            $display("FAIL fill_%0d: count=%0d af=%b f=%b e=%b ae=%b", i, count, almost_full,
                     full, empty, almost_empty);
            n_fail++;
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_overflow_drain();
      wr_en = 1'b1; wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      n_checks++;
      if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1}) begin
         $display("FAIL overflow: ovf=%b count=%0d full=%b want 1 8 1", overflow, count, full);
         n_fail++;
      end
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         tick();
         n_checks++;
         if ({rd_valid, rd_data, count} !== {1'b1, 8'h10 + 8'(i), 4'(7 - i)}) begin
            $display("FAIL drain_%0d: v=%b data=%h count=%0d want 1 %h %0d", i, rd_valid,
                     rd_data, count, 8'h10 + 8'(i), 7 - i);
            n_fail++;
         end
      end
      rd_en = 1'b0;
      tick();
      n_checks++;
      if ({empty, rd_valid, rd_data, overflow} !== {1'b1, 1'b0, 8'h17, 1'b1}) begin
         $display("FAIL drain_idle: e=%b v=%b data=%h ovf=%b want 1 0 17 1", empty, rd_valid,
                  rd_data, overflow);
         n_fail++;
      end
   endtask

   task automatic test_underflow();
      rd_en = 1'b1;
      tick();
      n_checks++;
      if ({underflow, rd_valid, count} !== {1'b1, 1'b0, 4'd0}) begin
         $display("FAIL underflow: udf=%b v=%b count=%0d want 1 0 0", underflow, rd_valid, count);
         n_fail++;
      end
      wr_en = 1'b1; wr_data = 8'h33;
      tick();
      wr_en = 1'b0;
      n_checks++;
      if ({count, rd_valid, empty} !== {4'd1, 1'b0, 1'b0}) begin
         $display("FAIL wr_rd_empty: count=%0d v=%b e=%b want 1 0 0", count, rd_valid, empty);
         n_fail++;
      end
      tick();
      rd_en = 1'b0;
      n_checks++;
      if ({rd_valid, rd_data, count} !== {1'b1, 8'h33, 4'd0}) begin
         $display("FAIL read_after_wr: v=%b data=%h count=%0d want 1 33 0", rd_valid, rd_data, count);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h44 + 8'(i);
         tick();
         n_checks++;
         if ({count, rd_valid, rd_data} !== {4'd4, 1'b1, 8'h40 + 8'(i)}) begin
            $display("FAIL b2b_%0d: count=%0d v=%b data=%h want 4 1 %h", i, count, rd_valid,
                     rd_data, 8'h40 + 8'(i));
            n_fail++;
         end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (rd_data !== 8'h4A + 8'(i)) begin
            $display("FAIL b2b_drain_%0d: data=%h want %h", i, rd_data, 8'h4A + 8'(i));
            n_fail++;
         end
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      n_checks++;
      if (count !== 4'd5) begin
         $display("FAIL mid_count: count=%0d want 5", count);
         n_fail++;
      end
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      n_checks++;
      if ({count, empty, overflow, underflow, rd_valid} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL mid_reset: count=%0d e=%b ovf=%b udf=%b v=%b want 0 1 0 0 0", count,
                  empty, overflow, underflow, rd_valid);
         n_fail++;
      end
   endtask

   task automatic test_fwft();
      wr_en1 = 1'b1; wr_data1 = 8'h5A;
      tick();
      wr_en1 = 1'b0;
      n_checks++;
      if ({rd_valid1, rd_data1, count1} !== {1'b1, 8'h5A, 4'd1}) begin
         $display("FAIL fwft_show: v=%b data=%h count=%0d want 1 5a 1", rd_valid1, rd_data1, count1);
         n_fail++;
      end
      wr_en1 = 1'b1; wr_data1 = 8'h5B;
      tick();
      wr_en1 = 1'b0; rd_en1 = 1'b1;
      tick();
      n_checks++;
      if ({rd_valid1, rd_data1, count1} !== {1'b1, 8'h5B, 4'd1}) begin
         $display("FAIL fwft_pop: v=%b data=%h count=%0d want 1 5b 1", rd_valid1, rd_data1, count1);
         n_fail++;
      end
      tick();
      rd_en1 = 1'b0;
      n_checks++;
      if ({rd_valid1, empty1, udf1} !== {1'b0, 1'b1, 1'b0}) begin
         $display("FAIL fwft_empty: v=%b e=%b udf=%b want 0 1 0", rd_valid1, empty1, udf1);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow_drain();
      test_underflow();
      test_back_to_back();
      test_mid_reset();
      test_fwft();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
